fft_out_reorder: RTL and testbench
==================================

Name: fft_out_reorder

Overview:
- Output stage of the 64-point FFT pipeline; the reader side of the butterfly chain.
- The butterfly stages emit each frame's bins in bit-reversed order. This block captures them into a ping-pong buffer and replays each frame in natural bin order (X[0]..X[63]).
- Runs at one sample per clock with no throughput loss.
- Samples are passed through unmodified, in the same signed two's-complement WIDTH format the butterflies produce.

Parameters:
- WIDTH, 17: bit width of each real/imag component (signed two's complement).
- LOG2N, 6: log2 of frame length; N = 2^LOG2N = 64.
- BITREV, 1: 1 = write address is the bit-reversed input index; 0 = write address equals the input index (debug pass-through order).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: input sample qualifier.
- in_start, input, 1: marks frame sample 0; sampled only when in_valid=1.
- in_re, input, WIDTH: real component, signed.
- in_im, input, WIDTH: imaginary component, signed.
- out_valid, output, 1: output sample qualifier (registered).
- out_first, output, 1: high with the bin 0 sample (registered).
- out_last, output, 1: high with the bin N-1 sample (registered).
- out_re, output, WIDTH: real component, natural order (registered).
- out_im, output, WIDTH: imaginary component, natural order (registered).

Behaviour:
- Storage: two banks of N entries x 2*WIDTH bits (bank 0, bank 1), plus one full flag per bank.
- Write side:
  - wr_bank (1 bit) and wr_cnt (LOG2N bits).
  - On in_valid=1: write {in_re, in_im} to bank[wr_bank] at address bitrev(wr_cnt) when BITREV=1, or wr_cnt when BITREV=0, then increment wr_cnt.
  - in_valid=0: no write, no count change; gaps of any length are allowed.
  - in_valid=1 with in_start=1: the sample is treated as index 0. wr_cnt is forced to 0 before addressing. Any partial frame in wr_bank is discarded and wr_bank is unchanged.
  - On the write of index N-1: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
- Read side FSM (rd_bank, rd_cnt):
  - IDLE: if full[rd_bank]=1, go to READ with rd_cnt=0.
  - READ: each cycle issue read address rd_cnt from bank[rd_bank] and increment rd_cnt.
  - READ at rd_cnt=N-1: clear full[rd_bank] and toggle rd_bank in that same cycle.
  - READ exit: go to IDLE, or stay in READ with rd_cnt=0 if the other bank is already full. Back-to-back frames then emit with no bubble.
- Output registers:
  - out_re/out_im/out_valid update one cycle after the read address is issued.
  - out_first=1 iff the issued address was 0; out_last=1 iff it was N-1.
  - When out_valid=0, out_re/out_im hold their last value; out_first and out_last are 0.
- Latency: the first output (bin 0) is valid 2 rising edges after the edge that captures input index N-1. For continuous input, frame latency from input index 0 to output bin 0 is N+1 = 65 cycles.
- Collision-free by construction:
  - The writer needs at least N cycles to fill a bank; the reader releases a bank exactly N cycles after starting it.
  - The writer therefore never writes into a bank with full=1, and no overflow logic is required.
  - Same-cycle set and clear of a full flag cannot occur, because they always target different banks.
- Reset:
  - Action: wr_bank=0, wr_cnt=0, rd_bank=0, rd_cnt=0, FSM=IDLE, both full flags=0.
  - Outputs: out_valid=0, out_first=0, out_last=0, out_re=0, out_im=0.
  - Buffer contents are not reset.
  - Reset mid-frame discards both in-flight frames. out_valid is 0 the cycle after rst is sampled high. The first post-reset frame behaves as after power-up.
- No arithmetic: data bits pass through unmodified (no scaling, rounding or sign handling).

Test Plan:
- Single-frame bit-reversal check:
  - Stimulus: reset, then 64 consecutive valid samples, in_start on the first; sample i has in_re=bitrev6(i), in_im=-bitrev6(i).
  - Response: out_re=0,1,...,63 and out_im=0,-1,...,-63 on consecutive cycles.
  - Response: out_first with 0, out_last with 63; first out_valid 2 edges after sample 63.
- Back-to-back frames:
  - Stimulus: 4 frames streamed with in_valid held high (256 cycles).
  - Response: 256 contiguous out_valid cycles with no bubble, each frame in natural order; frame k's bin 0 appears 65 cycles after its input index 0.
- Gapped input:
  - Stimulus: in_valid toggling 1,0,1,0 over one frame.
  - Response: output identical to the single-frame case, emitted contiguously 2 edges after the last input.
- Resynchronisation:
  - Stimulus: 20 samples, then in_start with a full new 64-sample frame.
  - Response: only the new frame is output; the 20 stale samples never appear.
- Reset mid-output:
  - Stimulus: assert rst for 1 cycle while bin 30 is being output.
  - Response: out_valid=0 from the next cycle; out_re/out_im=0; a following fresh frame is output correctly.
- BITREV=0:
  - Stimulus: samples 0..63 written in order.
  - Response: output order is 0..63, unchanged.

Source files
------------

// File: rtl/fft_out_reorder_if.sv
// Sample stream into and out of the FFT output reorder buffer.
// Producer drives in_*, the reorder block drives out_*.
interface fft_out_reorder_if #(
  parameter int WIDTH = 17
);
  logic                    in_valid;
  logic                    in_start;
  logic signed [WIDTH-1:0] in_re;
  logic signed [WIDTH-1:0] in_im;
  logic                    out_valid;
  logic                    out_first;
  logic                    out_last;
  logic signed [WIDTH-1:0] out_re;
  logic signed [WIDTH-1:0] out_im;

  modport master (
    output in_valid, in_start, in_re, in_im,
    input  out_valid, out_first, out_last, out_re, out_im
  );

  modport slave (
    input  in_valid, in_start, in_re, in_im,
    output out_valid, out_first, out_last, out_re, out_im
  );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong buffer replaying bit-reversed FFT bins in natural order; bin 0 leaves 2 edges after
// the frame's last input. No backpressure: one sample per clock in, reader always keeps pace.
module fft_out_reorder #(
  parameter int WIDTH  = 17,
  parameter int LOG2N  = 6,
  parameter int BITREV = 1
) (
  input logic              clk,
  input logic              rst,
  fft_out_reorder_if.slave bus
);
  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = '1;

  typedef enum logic {S_IDLE, S_READ} state_t;

  logic [2*WIDTH-1:0] r_mem [2*N];

  logic             r_wr_bank;
  logic [LOG2N-1:0] r_wr_cnt;
  logic [1:0]       r_full;

  state_t           r_state, w_state_nxt;
  logic             r_rd_bank, w_rd_bank_nxt;
  logic [LOG2N-1:0] r_rd_cnt, w_rd_cnt_nxt;
  logic             w_rd_en, w_rd_release, w_other_bank;

  logic [LOG2N-1:0] w_wr_idx, w_wr_addr;
  logic             w_wr_done;

  logic             r_out_valid, r_out_first, r_out_last;
  logic [WIDTH-1:0] r_out_re, r_out_im;

  // in_start restarts the current bank, dropping any partial frame
  assign w_wr_idx  = bus.in_start ? '0 : r_wr_cnt;
  assign w_wr_done = bus.in_valid && (w_wr_idx == LAST_IDX);

  generate
    if (BITREV != 0) begin : g_bitrev
      for (genvar b = 0; b < LOG2N; b++) begin : g_bit
        assign w_wr_addr[b] = w_wr_idx[LOG2N-1-b];
      end
    end else begin : g_linear
      assign w_wr_addr = w_wr_idx;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      r_mem[{r_wr_bank, w_wr_addr}] <= {bus.in_re, bus.in_im};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
    end else if (bus.in_valid) begin
      r_wr_cnt <= w_wr_idx + 1'b1;
      if (w_wr_done) r_wr_bank <= ~r_wr_bank;
    end
  end

  // Set and clear always hit different banks: a bank takes N cycles to fill and N to drain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= '0;
    end else begin
      if (w_wr_done)    r_full[r_wr_bank] <= 1'b1;
      if (w_rd_release) r_full[r_rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_bank <= w_rd_bank_nxt;
      r_rd_cnt  <= w_rd_cnt_nxt;
    end
  end

  assign w_other_bank = ~r_rd_bank;

  always_comb begin
    w_state_nxt   = r_state;
    w_rd_bank_nxt = r_rd_bank;
    w_rd_cnt_nxt  = r_rd_cnt;
    w_rd_en       = 1'b0;
    w_rd_release  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_state_nxt  = S_READ;
          w_rd_cnt_nxt = '0;
        end
      end
      S_READ: begin
        w_rd_en      = 1'b1;
        w_rd_cnt_nxt = r_rd_cnt + 1'b1;
        if (r_rd_cnt == LAST_IDX) begin
          w_rd_release  = 1'b1;
          w_rd_bank_nxt = w_other_bank;
          // chain straight into the next frame when it is already waiting
          w_state_nxt   = r_full[w_other_bank] ? S_READ : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
    end else begin
      r_out_valid <= w_rd_en;
      r_out_first <= w_rd_en && (r_rd_cnt == '0);
      r_out_last  <= w_rd_en && (r_rd_cnt == LAST_IDX);
      if (w_rd_en) begin
        {r_out_re, r_out_im} <= r_mem[{r_rd_bank, r_rd_cnt}];
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_first = r_out_first;
  assign bus.out_last  = r_out_last;
  assign bus.out_re    = r_out_re;
  assign bus.out_im    = r_out_im;
endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench: a frame-level model predicts every output cycle for a bit-reversing
// and a pass-through instance driven with identical stimulus.
module tb_fft_out_reorder;
  localparam int W = 17;
  localparam int N = 64;

  logic clk;
  logic rst;
  int   cyc  = 0;
  int   nvec = 0;
  int   nerr = 0;
  bit   mon_en = 0;

  fft_out_reorder_if #(.WIDTH(W)) bus_br ();
  fft_out_reorder_if #(.WIDTH(W)) bus_nr ();

  fft_out_reorder #(.WIDTH(W), .LOG2N(6), .BITREV(1)) dut_br (.clk(clk), .rst(rst), .bus(bus_br));
  fft_out_reorder #(.WIDTH(W), .LOG2N(6), .BITREV(0)) dut_nr (.clk(clk), .rst(rst), .bus(bus_nr));

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    bit           first;
    bit           last;
    int           cyc;
  } exp_t;

  exp_t           q_br[$];
  exp_t           q_nr[$];
  logic [2*W-1:0] part [N];
  int             pcnt = 0;
  logic [W-1:0]   hold_re [2];
  logic [W-1:0]   hold_im [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int bitrev6(int i);
    int r = 0;
    for (int b = 0; b < 6; b++) if (((i >> b) & 1) != 0) r |= 1 << (5 - b);
    return r;
  endfunction

  // A completed frame of N samples captured at edge e yields bin k at edge e+2+k
  task automatic model_in(bit s, logic [W-1:0] re, logic [W-1:0] im, int e);
    if (s) pcnt = 0;
    part[pcnt] = {re, im};
    pcnt++;
    if (pcnt == N) begin
      for (int k = 0; k < N; k++) begin
        exp_t x;
        logic [2*W-1:0] v;
        x.first = (k == 0);
        x.last  = (k == N - 1);
        x.cyc   = e + 2 + k;
        v = part[bitrev6(k)];
        x.re = v[2*W-1:W];
        x.im = v[W-1:0];
        q_br.push_back(x);
        v = part[k];
        x.re = v[2*W-1:W];
        x.im = v[W-1:0];
        q_nr.push_back(x);
      end
      pcnt = 0;
    end
  endtask

  task automatic drv(bit v, bit s, logic [W-1:0] re, logic [W-1:0] im);
    @(negedge clk);
    #1;
    bus_br.in_valid = v; bus_br.in_start = s; bus_br.in_re = re; bus_br.in_im = im;
    bus_nr.in_valid = v; bus_nr.in_start = s; bus_nr.in_re = re; bus_nr.in_im = im;
    if (v) model_in(s, re, im, cyc + 1);
  endtask

  task automatic idle(int n);
    repeat (n) drv(1'b0, 1'b0, W'($urandom), W'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    bus_br.in_valid = 1'b0;
    bus_nr.in_valid = 1'b0;
    pcnt = 0;
    q_br.delete();
    q_nr.delete();
    for (int d = 0; d < 2; d++) begin
      hold_re[d] = '0;
      hold_im[d] = '0;
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic frame_bitrev(bit gapped);
    for (int i = 0; i < N; i++) begin
      if (gapped && i != 0) drv(1'b0, 1'b0, '0, '0);
      drv(1'b1, i == 0, W'(bitrev6(i)), W'(-bitrev6(i)));
    end
  endtask

  task automatic frame_rand(int gap_pct);
    for (int i = 0; i < N; i++) begin
      while ($urandom_range(99) < gap_pct) drv(1'b0, 1'b0, W'($urandom), W'($urandom));
      drv(1'b1, i == 0, W'($urandom), W'($urandom));
    end
  endtask

  function automatic void check(int d);
    logic v, f, l;
    logic [W-1:0] re, im;
    exp_t e;
    bit have;
    have = 1'b0;
    if (d == 0) begin
      v = bus_br.out_valid; f = bus_br.out_first; l = bus_br.out_last;
      re = bus_br.out_re;   im = bus_br.out_im;
      if (q_br.size() > 0 && q_br[0].cyc == cyc) begin
        have = 1'b1;
        e = q_br.pop_front();
      end
    end else begin
      v = bus_nr.out_valid; f = bus_nr.out_first; l = bus_nr.out_last;
      re = bus_nr.out_re;   im = bus_nr.out_im;
      if (q_nr.size() > 0 && q_nr[0].cyc == cyc) begin
        have = 1'b1;
        e = q_nr.pop_front();
      end
    end
    if (have) begin
      hold_re[d] = e.re;
      hold_im[d] = e.im;
    end else begin
      e.re = hold_re[d];
      e.im = hold_im[d];
      e.first = 1'b0;
      e.last  = 1'b0;
    end
    nvec++;
    if (v !== have || f !== e.first || l !== e.last || re !== e.re || im !== e.im) begin
      nerr++;
      $display("FAIL %s cyc=%0d got valid=%0b first=%0b last=%0b re=%h im=%h want valid=%0b first=%0b last=%0b re=%h im=%h",
               (d == 0) ? "bitrev" : "linear", cyc, v, f, l, re, im, have, e.first, e.last, e.re, e.im);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check(0);
      check(1);
    end
  end

  initial begin
    rst = 1'b1;
    bus_br.in_valid = 1'b0; bus_br.in_start = 1'b0; bus_br.in_re = '0; bus_br.in_im = '0;
    bus_nr.in_valid = 1'b0; bus_nr.in_start = 1'b0; bus_nr.in_re = '0; bus_nr.in_im = '0;
    for (int d = 0; d < 2; d++) begin
      hold_re[d] = '0;
      hold_im[d] = '0;
    end
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;

    frame_bitrev(1'b0);
    idle(70);

    for (int f = 0; f < 4; f++) frame_rand(0);
    idle(70);

    frame_bitrev(1'b1);
    idle(70);

    // stale partial frame, then resync onto a fresh one
    for (int i = 0; i < 20; i++) drv(1'b1, i == 0, W'($urandom), W'($urandom));
    frame_rand(0);
    idle(70);

    // reset asserted while bin 30 is on the output
    frame_rand(0);
    idle(32);
    do_reset();
    frame_bitrev(1'b0);
    idle(70);

    for (int i = 0; i < N; i++) drv(1'b1, i == 0, W'(i), W'(~i));
    idle(70);

    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(2) == 0) begin
        int n = $urandom_range(40, 1);
        for (int i = 0; i < n; i++) drv(1'b1, i == 0, W'($urandom), W'($urandom));
      end
      frame_rand((f % 2 == 0) ? 0 : 40);
    end
    idle(80);

    nvec++;
    if (q_br.size() != 0 || q_nr.size() != 0) begin
      nerr++;
      $display("FAIL drain outstanding bitrev=%0d linear=%0d want 0", q_br.size(), q_nr.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
